// File: rtl/pe_array_sequencer.sv
// Tile-level sequencer for one systolic-array pass: weight load, skewed data feed, result drain.
// Optional weight reuse (skip LOAD_W) is enabled by defining PE_SEQ_WEIGHT_REUSE_EN.
module pe_array_sequencer #(
  parameter int ARRAY_SIZE = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(2*ARRAY_SIZE+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic [ADDR_WIDTH-1:0] d_base,
  input  logic [ADDR_WIDTH-1:0] r_base,
`ifdef PE_SEQ_WEIGHT_REUSE_EN
  input  logic                  reuse_w,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  w_rd_en,
  output logic [ADDR_WIDTH-1:0] w_rd_addr,
  output logic                  load_en,
  output logic                  d_rd_en,
  output logic [ADDR_WIDTH-1:0] d_rd_addr,
  output logic                  compute,
  output logic [CNT_WIDTH-1:0]  feed_cycle,
  output logic                  res_wr_en,
  output logic [ADDR_WIDTH-1:0] res_wr_addr
);

  typedef enum logic [2:0] {IDLE, LOAD_W, FEED, DRAIN, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] K_N     = CNT_WIDTH'(ARRAY_SIZE);
  localparam logic [CNT_WIDTH-1:0] K_N_M1  = CNT_WIDTH'(ARRAY_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] K_2N_M1 = CNT_WIDTH'(2*ARRAY_SIZE - 1);

  state_t                state, state_n;
  logic [CNT_WIDTH-1:0]  k, k_n;
  logic [ADDR_WIDTH-1:0] w_base_q, d_base_q, r_base_q;
  logic [ADDR_WIDTH-1:0] w_base_n, d_base_n, r_base_n;
  logic [ADDR_WIDTH-1:0] k_addr;

  assign k_addr = ADDR_WIDTH'(k_n);

  // Next state and phase counter; the counter restarts at 0 on every state entry.
  always_comb begin
    state_n  = state;
    k_n      = k + CNT_WIDTH'(1);
    w_base_n = w_base_q;
    d_base_n = d_base_q;
    r_base_n = r_base_q;
    case (state)
      IDLE: begin
        k_n = '0;
        if (start) begin
          w_base_n = w_base;
          d_base_n = d_base;
          r_base_n = r_base;
`ifdef PE_SEQ_WEIGHT_REUSE_EN
          state_n  = reuse_w ? FEED : LOAD_W;
`else
          state_n  = LOAD_W;
`endif
        end
      end
      LOAD_W: if (k == K_N) begin
        state_n = FEED;
        k_n     = '0;
      end
      FEED: if (k == K_2N_M1) begin
        state_n = DRAIN;
        k_n     = '0;
      end
      DRAIN: if (k == K_N_M1) begin
        state_n = DONE;
        k_n     = '0;
      end
      DONE: begin
        state_n = IDLE;
        k_n     = '0;
      end
      default: begin
        state_n = IDLE;
        k_n     = '0;
      end
    endcase
    if (abort && state != IDLE) begin
      state_n = IDLE;
      k_n     = '0;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      w_base_q    <= '0;
      d_base_q    <= '0;
      r_base_q    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      w_rd_en     <= 1'b0;
      w_rd_addr   <= '0;
      load_en     <= 1'b0;
      d_rd_en     <= 1'b0;
      d_rd_addr   <= '0;
      compute     <= 1'b0;
      feed_cycle  <= '0;
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
    end else begin
      state       <= state_n;
      k           <= k_n;
      w_base_q    <= w_base_n;
      d_base_q    <= d_base_n;
      r_base_q    <= r_base_n;
      busy        <= (state_n != IDLE);
      done        <= (state_n == DONE);
      w_rd_en     <= (state_n == LOAD_W) && (k_n < K_N);
      w_rd_addr   <= ((state_n == LOAD_W) && (k_n < K_N)) ? w_base_n + k_addr : '0;
      load_en     <= (state_n == LOAD_W) && (k_n != '0);
      d_rd_en     <= (state_n == FEED) && (k_n < K_N);
      d_rd_addr   <= ((state_n == FEED) && (k_n < K_N)) ? d_base_n + k_addr : '0;
      compute     <= (state_n == FEED) && (k_n != '0);
      feed_cycle  <= (state_n == FEED) ? k_n : '0;
      res_wr_en   <= (state_n == DRAIN);
      res_wr_addr <= (state_n == DRAIN) ? r_base_n + k_addr : '0;
    end
  end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Self-checking bench for pe_array_sequencer: timeline model checked every cycle plus directed literal checks.
module tb_pe_array_sequencer;

  localparam int N      = 8;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = $clog2(2*N+1);

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [ADDR_W-1:0] w_base, d_base, r_base;
`ifdef PE_SEQ_WEIGHT_REUSE_EN
  logic              reuse_w;
`endif
  logic              busy, done, w_rd_en, load_en, d_rd_en, compute, res_wr_en;
  logic [ADDR_W-1:0] w_rd_addr, d_rd_addr, res_wr_addr;
  logic [CNT_W-1:0]  feed_cycle;

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  pe_array_sequencer #(.ARRAY_SIZE(N), .ADDR_WIDTH(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .w_base(w_base), .d_base(d_base), .r_base(r_base),
`ifdef PE_SEQ_WEIGHT_REUSE_EN
    .reuse_w(reuse_w),
`endif
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .load_en(load_en),
    .d_rd_en(d_rd_en), .d_rd_addr(d_rd_addr), .compute(compute), .feed_cycle(feed_cycle),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a pass is a timeline of offsets o=1.. after the accepting edge.
  bit              m_active = 0, m_reuse = 0;
  int              m_o = 0;
  logic [ADDR_W-1:0] m_wb, m_db, m_rb;
  int              fs, lw, f, r;
  bit              e_w_en, e_load, e_d_en, e_comp, e_r_en, e_done;
  logic [ADDR_W-1:0] e_w_addr, e_d_addr, e_r_addr;
  int              e_fc;

  always @(negedge clk) begin
    if (checking) begin
      fs       = m_reuse ? 1 : N + 2;
      lw       = m_o - 1;
      f        = m_o - fs;
      r        = m_o - fs - 2*N;
      e_done   = m_active && (m_o == (m_reuse ? 3*N + 1 : 4*N + 2));
      e_w_en   = m_active && !m_reuse && lw >= 0 && lw < N;
      e_load   = m_active && !m_reuse && lw >= 1 && lw <= N;
      e_d_en   = m_active && f >= 0 && f < N;
      e_comp   = m_active && f >= 1 && f < 2*N;
      e_r_en   = m_active && r >= 0 && r < N;
      e_fc     = (m_active && f >= 0 && f < 2*N) ? f : 0;
      e_w_addr = e_w_en ? ADDR_W'(m_wb + lw) : '0;
      e_d_addr = e_d_en ? ADDR_W'(m_db + f) : '0;
      e_r_addr = e_r_en ? ADDR_W'(m_rb + r) : '0;
      checkOutput("busy", busy, m_active);
      checkOutput("done", done, e_done);
      checkOutput("w_rd_en", w_rd_en, e_w_en);
      checkOutput("w_rd_addr", w_rd_addr, e_w_addr);
      checkOutput("load_en", load_en, e_load);
      checkOutput("d_rd_en", d_rd_en, e_d_en);
      checkOutput("d_rd_addr", d_rd_addr, e_d_addr);
      checkOutput("compute", compute, e_comp);
      checkOutput("feed_cycle", feed_cycle, e_fc);
      checkOutput("res_wr_en", res_wr_en, e_r_en);
      checkOutput("res_wr_addr", res_wr_addr, e_r_addr);
    end
    // Inputs are stable here and are what the next rising edge will sample.
    if (rst) m_active = 0;
    else if (m_active) begin
      if (abort || m_o == (m_reuse ? 3*N + 1 : 4*N + 2)) m_active = 0;
      else m_o++;
    end else if (start) begin
      m_active = 1;
      m_o      = 1;
      m_wb     = w_base;
      m_db     = d_base;
      m_rb     = r_base;
`ifdef PE_SEQ_WEIGHT_REUSE_EN
      m_reuse  = reuse_w;
`else
      m_reuse  = 0;
`endif
    end
  end

  logic [79:0]       rec_done, rec_w_en, rec_load, rec_d_en, rec_comp, rec_r_en, rec_busy;
  logic [ADDR_W-1:0] rec_w[80], rec_d[80], rec_r[80];
  logic [CNT_W-1:0]  rec_fc[80];

  function automatic int firstHigh(input logic [79:0] v);
    for (int i = 1; i < 80; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic applyStimulus(input logic [ADDR_W-1:0] wb, db, rb, input bit reuse,
                               input int hold_len, input int abort_at, input bit abort_first,
                               input int n);
    {rec_done, rec_w_en, rec_load, rec_d_en, rec_comp, rec_r_en, rec_busy} = '0;
    @(posedge clk); #1;
    start = 1'b1; abort = abort_first;
    w_base = wb; d_base = db; r_base = rb;
`ifdef PE_SEQ_WEIGHT_REUSE_EN
    reuse_w = reuse;
`else
    if (reuse) $display("[TB] reuse requested but feature not built");
`endif
    for (int o = 1; o <= n; o++) begin
      @(posedge clk); #1;
      start = (o < hold_len);
      abort = (o == abort_at);
      @(negedge clk);
      rec_done[o] = done;    rec_w_en[o] = w_rd_en;  rec_load[o] = load_en;
      rec_d_en[o] = d_rd_en; rec_comp[o] = compute;  rec_r_en[o] = res_wr_en;
      rec_busy[o] = busy;    rec_w[o] = w_rd_addr;   rec_d[o] = d_rd_addr;
      rec_r[o] = res_wr_addr; rec_fc[o] = feed_cycle;
    end
    abort = 1'b0;
  endtask

  logic [ADDR_W-1:0] wrap_exp[8] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    w_base = '0; d_base = '0; r_base = '0;
`ifdef PE_SEQ_WEIGHT_REUSE_EN
    reuse_w = 1'b0;
`endif
    @(posedge clk); #1 checking = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      checkOutput("idle_busy", busy, 0);
    end

    // Basic pass with the reference bases.
    applyStimulus(8'h10, 8'h20, 8'h30, 0, 0, 0, 0, 40);
    checkOutput("done_at", firstHigh(rec_done), 34);
    checkOutput("done_count", $countones(rec_done), 1);
    checkOutput("w_addr_first", rec_w[1], 8'h10);
    checkOutput("w_addr_last", rec_w[8], 8'h17);
    checkOutput("w_en_count", $countones(rec_w_en), 8);
    checkOutput("load_first", firstHigh(rec_load), 2);
    checkOutput("load_count", $countones(rec_load), 8);
    checkOutput("d_first", firstHigh(rec_d_en), 10);
    checkOutput("d_addr_first", rec_d[10], 8'h20);
    checkOutput("d_addr_last", rec_d[17], 8'h27);
    checkOutput("compute_count", $countones(rec_comp), 15);
    checkOutput("feed_cycle_last", rec_fc[25], 15);
    checkOutput("res_first", firstHigh(rec_r_en), 26);
    checkOutput("res_addr_first", rec_r[26], 8'h30);
    checkOutput("res_addr_last", rec_r[33], 8'h37);
    checkOutput("busy_after", rec_busy[35], 0);

    // Weight address wraps modulo 256.
    applyStimulus(8'hFE, 8'h00, 8'h80, 0, 0, 0, 0, 40);
    for (int i = 0; i < 8; i++) checkOutput("w_wrap", rec_w[i+1], wrap_exp[i]);

    // start held high across a pass: second pass begins only after returning to IDLE.
    applyStimulus(8'h40, 8'h50, 8'h60, 0, 70, 0, 0, 75);
    checkOutput("hold_done_count", $countones(rec_done), 2);
    checkOutput("hold_done_first", firstHigh(rec_done), 34);
    checkOutput("hold_done_second", rec_done[69], 1);
    repeat (10) @(posedge clk);

    // Abort in FEED at k=5, then a clean pass.
    applyStimulus(8'h11, 8'h22, 8'h33, 0, 0, 15, 0, 45);
    checkOutput("abort_fc", rec_fc[15], 5);
    checkOutput("abort_busy", rec_busy[16], 0);
    checkOutput("abort_compute", rec_comp[16], 0);
    checkOutput("abort_d_en", rec_d_en[16], 0);
    checkOutput("abort_no_done", $countones(rec_done), 0);
    applyStimulus(8'h01, 8'h02, 8'h03, 0, 0, 0, 0, 40);
    checkOutput("post_abort_done", firstHigh(rec_done), 34);

    // abort together with start in IDLE does not block acceptance.
    applyStimulus(8'h70, 8'h71, 8'h72, 0, 0, 0, 1, 40);
    checkOutput("idle_abort_busy", rec_busy[1], 1);
    checkOutput("idle_abort_w_en", rec_w_en[1], 1);
    checkOutput("idle_abort_done", firstHigh(rec_done), 34);

    // Reset mid-pass wins over start.
    applyStimulus(8'h05, 8'h06, 8'h07, 0, 0, 0, 0, 5);
    @(posedge clk); #1 rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_w_en", w_rd_en, 0);
    repeat (3) @(posedge clk);

`ifdef PE_SEQ_WEIGHT_REUSE_EN
    applyStimulus(8'h10, 8'h20, 8'h30, 1, 0, 0, 0, 30);
    checkOutput("reuse_done_at", firstHigh(rec_done), 25);
    checkOutput("reuse_w_en", $countones(rec_w_en), 0);
    checkOutput("reuse_load", $countones(rec_load), 0);
    checkOutput("reuse_d_addr", rec_d[1], 8'h20);
    #1 reuse_w = 1'b0;
    repeat (3) @(posedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
